// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_pkg;

  localparam int unsigned WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam logic [WIDTH-1:0] ONE           = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DIVZ_QUOTIENT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SIGNED_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  // Conditional two's-complement negation.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x) + ONE : x;
  endfunction

endpackage

// File: rtl/radix2_divider_if.sv
// Operand and result valid/ready handshakes of the divider.
interface radix2_divider_if;
  import div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/Knowles.sv
// 64-bit parallel-prefix adder (Knowles [1,1,1,1,1,1], minimum fan-out) with carry in/out.
module Knowles
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned Levels = $clog2(WIDTH);

  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  always_comb begin
    p0   = a ^ b;
    g    = a & b;
    p    = p0;
    // Fold the carry-in into bit 0 so every group generate is a true carry.
    g[0] = g[0] | (p0[0] & cin);
    for (int lvl = 0; lvl < int'(Levels); lvl++) begin
      // Descending index keeps the lower operand at its previous-level value.
      for (int i = int'(WIDTH) - 1; i >= (1 << lvl); i--) begin
        g[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
        p[i] = p[i] & p[i - (1 << lvl)];
      end
    end
  end

  assign sum  = p0 ^ {g[WIDTH-2:0], cin};
  assign cout = g[WIDTH-1];

endmodule

// File: rtl/radix2_divider.sv
// Iterative signed/unsigned 64-bit restoring divider, one quotient bit per cycle.
module radix2_divider
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  radix2_divider_if.slave   bus
);

  div_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic             is_divz, is_ovf, is_special;
  logic [WIDTH-1:0] rem_shifted, dvs_inv, add_sum;
  logic             add_cout, trial_ok;

  assign a_neg      = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg      = bus.is_signed & bus.divisor[WIDTH-1];
  assign is_divz    = (bus.divisor == '0);
  assign is_ovf     = bus.is_signed & (bus.dividend == SIGNED_MIN) &
                      (bus.divisor == DIVZ_QUOTIENT);
  assign is_special = is_divz | is_ovf;

  // Trial subtraction: rem_shifted - divisor as rem_shifted + ~divisor + 1.
  assign rem_shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign dvs_inv     = ~dvs_q;
  assign trial_ok    = rem_q[WIDTH-1] | add_cout;

  Knowles u_knowles (
    .a    (rem_shifted),
    .b    (dvs_inv),
    .cin  (1'b1),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = is_special ? DONE : CALC;
      CALC: if (cnt_q == 6'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode from the state register only.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_neg_d = 1'b0;
          r_neg_d = 1'b0;
          dbz_d   = 1'b0;
          if (is_divz) begin
            quo_d = DIVZ_QUOTIENT;
            rem_d = bus.dividend;
            dbz_d = 1'b1;
          end else if (is_ovf) begin
            quo_d = bus.dividend;
            rem_d = '0;
          end else begin
            quo_d   = cond_neg(bus.dividend, a_neg);
            dvs_d   = cond_neg(bus.divisor, b_neg);
            rem_d   = '0;
            cnt_d   = 6'd63;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end
        end
      end
      CALC: begin
        rem_d = trial_ok ? add_sum : rem_shifted;
        quo_d = {quo_q[WIDTH-2:0], trial_ok};
        cnt_d = cnt_q - 6'd1;
      end
      FIX: begin
        quo_d = cond_neg(quo_q, q_neg_q);
        rem_d = cond_neg(rem_q, r_neg_q);
      end
      DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
